id_issue_buffer: RTL
====================

Name: id_issue_buffer

Overview:
- Parametrised instruction buffer plus register scoreboard between Fetch and the decode/ID_EX register of the 5-stage RV32I pipeline.
- Decouples fetch from decode with a DEPTH-entry FIFO using valid/ready handshakes.
- Issues the head instruction only when its source and destination registers are hazard-free.
- Replaces fixed destination-register comparison with per-register pending tracking, including optional forwarding-aware mode and flush recovery.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- XLEN, 32, PC width.
- NUM_REGS, 32, architectural registers (16 for RV32E); REG_AW = $clog2(NUM_REGS).
- FORWARD_EN, 0, 1 = only load-pending registers block RAW issue; non-load results are treated as forwarded.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  buffer can accept (= !full)
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  head instruction issuable
- out_ready  in  1  decode/ID_EX accepts head
- out_instr  out  32  head instruction (0 when empty)
- out_pc  out  XLEN  head PC (0 when empty)
- wb_valid  in  1  writeback occurring this cycle
- wb_addr  in  REG_AW  writeback register
- flush  in  1  squash buffered instructions
- kill_valid  in  1  with flush: issued instruction in ID_EX is squashed
- kill_rd  in  REG_AW  destination of squashed instruction
- occupancy  out  $clog2(DEPTH+1)  entries held
- stall_op  out  1  head valid but blocked by hazard

Behaviour:
- Reset (async, reset=0): FIFO pointers and count = 0; all pending and pending_load bits = 0; out_valid = 0; out_instr/out_pc = 0; occupancy = 0; stall_op = 0. in_ready = 1 while count = 0, but no push is accepted while reset is asserted. Reset mid-operation discards everything.
- Push: in_valid & in_ready writes the entry at the tail. The entry is first visible at the head the next cycle (minimum latency 1; no empty bypass).
- Full: in_ready = 0 and in_valid is ignored. Push and pop in the same cycle at count = DEPTH is impossible (in_ready = 0); at any other count, simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
- Register usage decode (opcode[6:0]):
  - OP: rs1, rs2, rd.
  - OPIMM, LOAD, JALR: rs1, rd.
  - STORE, BRANCH: rs1, rs2.
  - JAL, LUI, AUIPC: rd.
  - Other opcodes: no register use.
  - Register fields are truncated to REG_AW bits. Register 0 is never used, set or blocking.
- Hazard (head entry, from registered pending state only; no same-cycle wb bypass):
  - RAW: a used rs with pending[rs] & (!FORWARD_EN | pending_load[rs]).
  - WAW: rd writes and pending[rd]. This guarantees at most one in-flight writer per register.
- Outputs: out_valid = !empty & !hazard; stall_op = !empty & hazard.
- Issue: on out_valid & out_ready, pop the head. If it writes rd≠0, set pending[rd] = 1 and pending_load[rd] = (opcode==LOAD).
- Writeback: wb_valid & wb_addr≠0 clears pending[wb_addr] and pending_load[wb_addr] at the clock edge. If an issue set and a wb/kill clear hit the same register in one cycle, the set wins (unreachable under the WAW rule; still required).
- Flush (synchronous):
  - Next cycle count = 0 and pointers = 0.
  - out_valid is forced to 0 in the flush cycle, so no pop occurs.
  - A push in the flush cycle is dropped.
  - kill_valid & kill_rd≠0 clears pending[kill_rd] and pending_load[kill_rd].
  - Other pending bits are kept, because older instructions still write back.
- occupancy = count (registered).

Decomposition:
- Shared package (CORE_PKG): opcode constants (OPCODE_OP … OPCODE_BRANCH), plus a packed reg_usage_t {use_rs1, use_rs2, use_rd, is_load}.
- One combinational sub-module, instr_reg_usage: instruction in, reg_usage_t plus rs1/rs2/rd out.
- FIFO storage, pointers and scoreboard stay in id_issue_buffer.

Test Plan:
- DEPTH=4, out_ready=0, push 5 instructions back-to-back → occupancy 4, in_ready=0 after the 4th, 5th not accepted; out_ready=1 then pops them in order with matching out_pc.
- FORWARD_EN=0: addi x5,x0,1 then add x6,x5,x5 → second held with stall_op=1 until a wb_valid/wb_addr=5 cycle; issues the cycle after.
- FORWARD_EN=1: addi x5 then add x6,x5,x5 issue on consecutive cycles. lw x5,0(x1) then add x6,x5,x0 → stall until wb_addr=5.
- WAW: addi x7,x0,1 then addi x7,x0,2 → second blocked until wb_addr=7. addi x0,x0,0 then add x1,x0,x0 → no stall, no pending set.
- Three entries buffered, x9 pending from an issued instruction, flush with kill_valid=1/kill_rd=9 plus concurrent in_valid → occupancy 0, pending[9]=0, pushed instruction absent.
- Assert reset=0 mid-stream with 2 entries buffered and x4 pending → out_valid=0 and occupancy=0 immediately; after release, add x1,x4,x4 issues without stall.

Source files
------------

// File: rtl/id_issue_buffer_pkg.sv
// Shared opcode constants and register-usage record for the ID issue buffer.
package id_issue_buffer_pkg;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic use_rd;
        logic is_load;
    } reg_usage_t;

endpackage

// File: rtl/id_issue_buffer_usage.sv
// Combinational decode of which register fields an RV32I instruction reads/writes.
module instr_reg_usage
    import id_issue_buffer_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [31:0]       instr,
    output reg_usage_t        usage,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output logic [REG_AW-1:0] rd
);

    reg_usage_t dec_s;
    logic       unused_bits_s;

    assign rs1 = instr[15 +: REG_AW];
    assign rs2 = instr[20 +: REG_AW];
    assign rd  = instr[7 +: REG_AW];
    assign unused_bits_s = &{1'b0, instr};

    // Opcode class to field usage; x0 never counts as a use.
    always_comb begin
        dec_s = '0;
        case (instr[6:0])
            OPCODE_OP:     dec_s = '{use_rs1: 1'b1, use_rs2: 1'b1, use_rd: 1'b1, is_load: 1'b0};
            OPCODE_OPIMM:  dec_s = '{use_rs1: 1'b1, use_rs2: 1'b0, use_rd: 1'b1, is_load: 1'b0};
            OPCODE_LOAD:   dec_s = '{use_rs1: 1'b1, use_rs2: 1'b0, use_rd: 1'b1, is_load: 1'b1};
            OPCODE_JALR:   dec_s = '{use_rs1: 1'b1, use_rs2: 1'b0, use_rd: 1'b1, is_load: 1'b0};
            OPCODE_STORE:  dec_s = '{use_rs1: 1'b1, use_rs2: 1'b1, use_rd: 1'b0, is_load: 1'b0};
            OPCODE_BRANCH: dec_s = '{use_rs1: 1'b1, use_rs2: 1'b1, use_rd: 1'b0, is_load: 1'b0};
            OPCODE_JAL:    dec_s = '{use_rs1: 1'b0, use_rs2: 1'b0, use_rd: 1'b1, is_load: 1'b0};
            OPCODE_LUI:    dec_s = '{use_rs1: 1'b0, use_rs2: 1'b0, use_rd: 1'b1, is_load: 1'b0};
            OPCODE_AUIPC:  dec_s = '{use_rs1: 1'b0, use_rs2: 1'b0, use_rd: 1'b1, is_load: 1'b0};
            default:       dec_s = '0;
        endcase
        usage.use_rs1 = dec_s.use_rs1 & (rs1 != {REG_AW{1'b0}});
        usage.use_rs2 = dec_s.use_rs2 & (rs2 != {REG_AW{1'b0}});
        usage.use_rd  = dec_s.use_rd  & (rd  != {REG_AW{1'b0}});
        usage.is_load = dec_s.is_load;
    end

endmodule

// File: rtl/id_issue_buffer.sv
// Fetch-to-decode instruction FIFO with a per-register pending scoreboard gating issue.
module id_issue_buffer
    import id_issue_buffer_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int XLEN       = 32,
    parameter int NUM_REGS   = 32,
    parameter int FORWARD_EN = 0,
    localparam int REG_AW    = $clog2(NUM_REGS),
    localparam int CNT_W     = $clog2(DEPTH + 1),
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [XLEN-1:0]   out_pc,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic              flush,
    input  logic              kill_valid,
    input  logic [REG_AW-1:0] kill_rd,
    output logic [CNT_W-1:0]  occupancy,
    output logic              stall_op
);

    logic [31:0]         mem_instr_r [DEPTH];
    logic [XLEN-1:0]     mem_pc_r    [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic [NUM_REGS-1:0] pending_r;
    logic [NUM_REGS-1:0] pending_load_r;

    logic                empty_s;
    logic                full_s;
    logic                push_s;
    logic                pop_s;
    logic                hazard_s;
    logic [31:0]         head_instr_s;
    reg_usage_t          usage_s;
    logic [REG_AW-1:0]   rs1_s;
    logic [REG_AW-1:0]   rs2_s;
    logic [REG_AW-1:0]   rd_s;
    logic [NUM_REGS-1:0] clr_mask_s;
    logic [NUM_REGS-1:0] set_mask_s;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] idx,
                                                       input logic en);
        reg_onehot = en ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << idx) : {NUM_REGS{1'b0}};
    endfunction

    // With forwarding only an outstanding load can stall a reader.
    function automatic logic raw_block(input logic used, input logic pend, input logic pend_load);
        raw_block = used & pend & ((FORWARD_EN == 0) | pend_load);
    endfunction

    assign empty_s      = (count_r == {CNT_W{1'b0}});
    assign full_s       = (count_r == CNT_W'(DEPTH));
    assign head_instr_s = mem_instr_r[rd_ptr_r];

    instr_reg_usage #(.REG_AW(REG_AW)) u_usage (
        .instr (head_instr_s),
        .usage (usage_s),
        .rs1   (rs1_s),
        .rs2   (rs2_s),
        .rd    (rd_s)
    );

    assign hazard_s = raw_block(usage_s.use_rs1, pending_r[rs1_s], pending_load_r[rs1_s])
                    | raw_block(usage_s.use_rs2, pending_r[rs2_s], pending_load_r[rs2_s])
                    | (usage_s.use_rd & pending_r[rd_s]);

    assign in_ready  = ~full_s;
    assign out_valid = ~empty_s & ~hazard_s & ~flush;
    assign stall_op  = ~empty_s & hazard_s;
    assign occupancy = count_r;
    assign push_s    = in_valid & ~full_s & ~flush;
    assign pop_s     = out_valid & out_ready;

    // Head presentation, zeroed when nothing is buffered.
    always_comb begin
        if (empty_s) begin
            out_instr = 32'h0;
            out_pc    = {XLEN{1'b0}};
        end else begin
            out_instr = head_instr_s;
            out_pc    = mem_pc_r[rd_ptr_r];
        end
    end

    // Issue set is applied after clears so it wins on a collision.
    assign clr_mask_s = reg_onehot(wb_addr, wb_valid & (wb_addr != {REG_AW{1'b0}}))
                      | reg_onehot(kill_rd, flush & kill_valid & (kill_rd != {REG_AW{1'b0}}));
    assign set_mask_s = reg_onehot(rd_s, pop_s & usage_s.use_rd);

    // FIFO storage, pointers and entry count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr_r[i] <= 32'h0;
                mem_pc_r[i]    <= {XLEN{1'b0}};
            end
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_instr_r[wr_ptr_r] <= in_instr;
                mem_pc_r[wr_ptr_r]    <= in_pc;
                wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Register scoreboard; bit 0 can never be set because x0 is never a use.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_r      <= {NUM_REGS{1'b0}};
            pending_load_r <= {NUM_REGS{1'b0}};
        end else begin
            pending_r      <= (pending_r & ~clr_mask_s) | set_mask_s;
            pending_load_r <= (pending_load_r & ~clr_mask_s & ~set_mask_s)
                            | (usage_s.is_load ? set_mask_s : {NUM_REGS{1'b0}});
        end
    end

endmodule
